// File: rtl/pkt_rr_arbiter.sv
// Round-robin packet arbiter: grants one input queue per packet and forwards its words downstream.
// Latency: accepted word appears on out_* one cycle later; one idle arbitration cycle between packets.
// Backpressure: out_rdy gates in_rdy of the granted queue only; optional per-queue EOP counters via PKT_RR_ARBITER_PKT_CNT_EN.
module pkt_rr_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8,
    parameter int NUM_QUEUES = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_QUEUES-1:0]            in_req,
    input  logic [NUM_QUEUES*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_QUEUES*CTRL_WIDTH-1:0] in_ctrl,
    input  logic [NUM_QUEUES-1:0]            in_wr,
    output logic [NUM_QUEUES-1:0]            in_rdy,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic [CTRL_WIDTH-1:0]            out_ctrl,
    output logic                             out_wr,
    input  logic                             out_rdy,
    output logic                             err_spurious_wr
`ifdef PKT_RR_ARBITER_PKT_CNT_EN
    ,
    output logic [NUM_QUEUES*16-1:0]         pkt_cnt
`endif
);

    localparam int GW = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_HDR  = 3'b010,
        ST_BODY = 3'b100
    } state_t;

    state_t                  r_state, w_state_nxt;
    logic [GW-1:0]           r_grant, r_last_grant, w_grant_nxt, w_pick;
    logic [NUM_QUEUES-1:0]   w_gnt_mask;
    logic [DATA_WIDTH-1:0]   w_gdata;
    logic [CTRL_WIDTH-1:0]   w_gctrl;
    logic                    w_any_req, w_acc, w_spur, w_eop, w_ctrl_zero;
    logic [DATA_WIDTH-1:0]   r_out_data;
    logic [CTRL_WIDTH-1:0]   r_out_ctrl;
    logic                    r_out_wr, r_err;

    assign w_any_req   = |in_req;
    assign in_rdy      = w_gnt_mask & {NUM_QUEUES{out_rdy}};
    assign w_acc       = |(in_wr & in_rdy);
    assign w_spur      = |(in_wr & ~w_gnt_mask);
    assign w_ctrl_zero = (w_gctrl == '0);

    // Search upward from last_grant+1 with wrap; the nearest requester wins.
    always_comb begin : p_pick
        logic [GW:0] idx;
        logic        found;
        w_pick = r_last_grant;
        found  = 1'b0;
        idx    = '0;
        for (int k = 1; k <= NUM_QUEUES; k++) begin
            idx = {1'b0, r_last_grant} + (GW+1)'(k);
            if (idx >= (GW+1)'(NUM_QUEUES))
                idx = idx - (GW+1)'(NUM_QUEUES);
            if (!found && in_req[idx[GW-1:0]]) begin
                found  = 1'b1;
                w_pick = idx[GW-1:0];
            end
        end
    end

    always_comb begin
        w_gnt_mask = '0;
        w_gdata    = '0;
        w_gctrl    = '0;
        for (int i = 0; i < NUM_QUEUES; i++) begin
            if (r_grant == GW'(i)) begin
                w_gnt_mask[i] = (r_state != ST_IDLE);
                w_gdata       = in_data[i*DATA_WIDTH +: DATA_WIDTH];
                w_gctrl       = in_ctrl[i*CTRL_WIDTH +: CTRL_WIDTH];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_eop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = ST_HDR;
                    w_grant_nxt = w_pick;
                end
            end
            ST_HDR: begin
                if (w_acc && w_ctrl_zero)
                    w_state_nxt = ST_BODY;
            end
            ST_BODY: begin
                if (w_acc && !w_ctrl_zero) begin
                    w_state_nxt = ST_IDLE;
                    w_eop       = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_last_grant <= GW'(NUM_QUEUES - 1);
            r_out_wr     <= 1'b0;
            r_out_data   <= '0;
            r_out_ctrl   <= '0;
            r_err        <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_out_wr <= w_acc;
            if (w_eop)
                r_last_grant <= r_grant;
            if (w_acc) begin
                r_out_data <= w_gdata;
                r_out_ctrl <= w_gctrl;
            end
            if (w_spur)
                r_err <= 1'b1;
        end
    end

    assign out_wr          = r_out_wr;
    assign out_data        = r_out_data;
    assign out_ctrl        = r_out_ctrl;
    assign err_spurious_wr = r_err;

`ifdef PKT_RR_ARBITER_PKT_CNT_EN
    logic [15:0] r_pkt_cnt [NUM_QUEUES];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_QUEUES; i++)
                r_pkt_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_QUEUES; i++)
                if (w_eop && (r_grant == GW'(i)))
                    r_pkt_cnt[i] <= r_pkt_cnt[i] + 16'd1;
        end
    end

    always_comb begin
        pkt_cnt = '0;
        for (int i = 0; i < NUM_QUEUES; i++)
            pkt_cnt[i*16 +: 16] = r_pkt_cnt[i];
    end
`endif

endmodule

// File: tb/tb_pkt_rr_arbiter.sv
// Directed bench for pkt_rr_arbiter: expected words are queued when driven and checked as they leave.
module tb_pkt_rr_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   in_req;
    logic [255:0] in_data;
    logic [31:0]  in_ctrl;
    logic [3:0]   in_wr;
    logic [3:0]   in_rdy;
    logic [63:0]  out_data;
    logic [7:0]   out_ctrl;
    logic         out_wr;
    logic         out_rdy;
    logic         err_spurious_wr;
`ifdef PKT_RR_ARBITER_PKT_CNT_EN
    logic [63:0]  pkt_cnt;
`endif

    typedef struct {
        logic [63:0] d;
        logic [7:0]  c;
    } exp_t;

    exp_t sb[$];
    int   vectors    = 0;
    int   miscompares = 0;
    int   seq        = 0;

    always #5 clk = ~clk;

    pkt_rr_arbiter dut (
        .clk             (clk),
        .reset           (reset),
        .in_req          (in_req),
        .in_data         (in_data),
        .in_ctrl         (in_ctrl),
        .in_wr           (in_wr),
        .in_rdy          (in_rdy),
        .out_data        (out_data),
        .out_ctrl        (out_ctrl),
        .out_wr          (out_wr),
        .out_rdy         (out_rdy),
        .err_spurious_wr (err_spurious_wr)
`ifdef PKT_RR_ARBITER_PKT_CNT_EN
        ,
        .pkt_cnt         (pkt_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_word(input int q, input logic [63:0] d, input logic [7:0] c);
        in_wr   = 4'(1 << q);
        in_data = '0;
        in_ctrl = '0;
        in_data[q*64 +: 64] = d;
        in_ctrl[q*8 +: 8]   = c;
    endtask

    function automatic logic [63:0] mk_data(input int q, input int s);
        return {8'(q), 24'hC0FFEE, 32'(s)};
    endfunction

    // Output monitor: every out_wr must match the oldest queued word.
    always @(negedge clk) begin
        if (!reset && out_wr === 1'b1) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $error("FAIL unexpected_out: observed %0h/%0h expected no word", out_data, out_ctrl);
            end else begin
                exp_t e;
                e = sb.pop_front();
                assert ({out_data, out_ctrl} === {e.d, e.c}) else begin
                    miscompares++;
                    $error("FAIL out_word: observed %0h/%0h expected %0h/%0h", out_data, out_ctrl, e.d, e.c);
                end
            end
        end
    end

    // Called just after a negedge with the DUT idle and in_req already set so that q wins.
    task automatic run_pkt(input int q, input int nbody, input int stall_at, input int stall_len,
                           input logic [3:0] mid_req, input int spur_q);
        int n;
        n = nbody + 2;
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            logic [7:0]  c;
            logic [63:0] d;
            c = (i == 0) ? 8'hFF : ((i == n - 1) ? 8'h80 : 8'h00);
            d = mk_data(q, seq);
            if (i == 2)
                in_req = in_req | mid_req;
            if (i == stall_at) begin
                out_rdy = 1'b0;
                drive_word(q, d, c);
                for (int s = 0; s < stall_len; s++) begin
                    #1 chk("stall_rdy", 64'(in_rdy), 64'h0);
                    @(negedge clk);
                end
                out_rdy = 1'b1;
            end
            #1 chk("grant_rdy", 64'(in_rdy), 64'(1 << q));
            drive_word(q, d, c);
            if (i == 1 && spur_q >= 0) begin
                in_wr[spur_q] = 1'b1;
                in_data[spur_q*64 +: 64] = 64'hDEAD_BEEF_0BAD_F00D;
                in_ctrl[spur_q*8 +: 8]   = 8'h80;
            end
            sb.push_back('{d: d, c: c});
            seq++;
            @(negedge clk);
        end
        in_wr = '0;
        #1 chk("bubble_rdy", 64'(in_rdy), 64'h0);
    endtask

    initial begin
        reset   = 1'b1;
        in_req  = '0;
        in_data = '0;
        in_ctrl = '0;
        in_wr   = '0;
        out_rdy = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_out_wr",   64'(out_wr), 64'h0);
        chk("rst_out_data", out_data, 64'h0);
        chk("rst_out_ctrl", 64'(out_ctrl), 64'h0);
        chk("rst_in_rdy",   64'(in_rdy), 64'h0);
        chk("rst_err",      64'(err_spurious_wr), 64'h0);

        // Single packet from queue 0: hdr, 2 data, EOP.
        in_req = 4'b0001;
        run_pkt(0, 2, -1, 0, 4'b0000, -1);
        in_req = '0;
        @(negedge clk);
        #1 chk("idle_hold", 64'(in_rdy), 64'h0);

        // All requesting: strict rotation 1,2,3,0 with one bubble each.
        in_req = 4'b1111;
        run_pkt(1, 1, -1, 0, 4'b0000, -1);
        run_pkt(2, 2, -1, 0, 4'b0000, -1);
        run_pkt(3, 1, -1, 0, 4'b0000, -1);
        run_pkt(0, 3, -1, 0, 4'b0000, -1);

        // Queue 2 mid-body sees queue 0 request; no preemption, then wrap past idle queue 3 to 0.
        in_req = 4'b0100;
        run_pkt(2, 3, -1, 0, 4'b0001, -1);
        run_pkt(0, 1, -1, 0, 4'b0000, -1);

        // Downstream stall of 5 cycles mid-body.
        in_req = 4'b0010;
        run_pkt(1, 4, 2, 5, 4'b0000, -1);

        // Spurious write from queue 1 while queue 3 is granted.
        in_req = 4'b1000;
        chk("err_before", 64'(err_spurious_wr), 64'h0);
        run_pkt(3, 2, -1, 0, 4'b0000, 1);
        chk("err_set", 64'(err_spurious_wr), 64'h1);
        in_req = '0;
        repeat (2) @(negedge clk);
        #1 chk("err_sticky", 64'(err_spurious_wr), 64'h1);
`ifdef PKT_RR_ARBITER_PKT_CNT_EN
        chk("pkt_cnt", pkt_cnt, {16'd2, 16'd2, 16'd2, 16'd3});
`endif

        // Reset mid-body of queue 1.
        in_req = 4'b0010;
        @(negedge clk);
        #1 chk("grant_q1", 64'(in_rdy), 64'h2);
        drive_word(1, mk_data(1, seq), 8'hFF);
        sb.push_back('{d: mk_data(1, seq), c: 8'hFF});
        seq++;
        @(negedge clk);
        drive_word(1, mk_data(1, seq), 8'h00);
        sb.push_back('{d: mk_data(1, seq), c: 8'h00});
        seq++;
        @(negedge clk);
        drive_word(1, mk_data(1, seq), 8'h00);
        sb.push_back('{d: mk_data(1, seq), c: 8'h00});
        seq++;
        @(negedge clk);
        drive_word(1, mk_data(1, seq), 8'h00);
        in_req = '0;
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_out_wr", 64'(out_wr), 64'h0);
        chk("rst_mid_in_rdy", 64'(in_rdy), 64'h0);
        chk("rst_mid_err",    64'(err_spurious_wr), 64'h0);
        in_wr = '0;
`ifdef PKT_RR_ARBITER_PKT_CNT_EN
        chk("rst_pkt_cnt", pkt_cnt, 64'h0);
`endif
        @(negedge clk);
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("post_rst_out_wr", 64'(out_wr), 64'h0);
        chk("post_rst_in_rdy", 64'(in_rdy), 64'h0);

        // After reset queue 0 wins first.
        in_req = 4'b1111;
        run_pkt(0, 1, -1, 0, 4'b0000, -1);
        in_req = '0;

        // Any write while idle is spurious.
        @(negedge clk);
        drive_word(2, 64'h1234, 8'h80);
        @(negedge clk);
        in_wr = '0;
        #1 chk("err_idle_wr", 64'(err_spurious_wr), 64'h1);
        repeat (2) @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
